// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle shared by instruction decode, the ALU
// sequencer and register-file writeback.
interface alu_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic             resp_cout;
   logic             resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_cout, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_result, resp_cout, resp_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer driving a 16-slice ripple ALU: single-pass ops, SLL by repeated
// doubling, and (with ALUSEQ_MUL_EN defined) shift-add multiply.
module alu_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_sequencer_if.slave   bus,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             a_invert,
   output logic             b_invert,
   output logic             cin,
   output logic [2:0]       operation,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [SW-1:0] CNT_ONE = SW'(1);

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_NOR = 4'd6;
   localparam logic [3:0] OP_SLL = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_LESS = 3'b101;

`ifdef ALUSEQ_MUL_EN
   typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MUL, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, EXEC, SHIFT, DONE} state_t;
`endif

   state_t           state;
   logic [3:0]       op_q;
   logic [SW-1:0]    cnt;
   logic             ready_q;
   logic             valid_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             err_q;
   logic             illegal;
   logic             arith;

   assign bus.req_ready   = ready_q;
   assign bus.resp_valid  = valid_q;
   assign bus.resp_result = result_q;
   assign bus.resp_cout   = cout_q;
   assign bus.resp_err    = err_q;

   // Only ops 0-7 can reach EXEC legally; op 8 lands there only without MUL.
   assign illegal = (op_q >= OP_MUL);
   assign arith   = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                    (op_q == OP_SLT) || (op_q == OP_SLL);

`ifdef ALUSEQ_MUL_EN
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc_next;

   assign acc_next = mplier[0] ? alu_result : acc;
`endif

   // ALU controls default to zero each cycle; only states that keep the ALU busy re-drive them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= '0;
         cnt       <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         err_q     <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         a_invert  <= 1'b0;
         b_invert  <= 1'b0;
         cin       <= 1'b0;
         operation <= ALU_AND;
`ifdef ALUSEQ_MUL_EN
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
`endif
      end else begin
         alu_a     <= '0;
         alu_b     <= '0;
         a_invert  <= 1'b0;
         b_invert  <= 1'b0;
         cin       <= 1'b0;
         operation <= ALU_AND;

         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q    <= bus.req_op;
                  ready_q <= 1'b0;
                  state   <= EXEC;
                  case (bus.req_op)
                     OP_AND: begin
                        alu_a <= bus.req_a;
                        alu_b <= bus.req_b;
                     end
                     OP_OR: begin
                        alu_a     <= bus.req_a;
                        alu_b     <= bus.req_b;
                        operation <= ALU_OR;
                     end
                     OP_XOR: begin
                        alu_a     <= bus.req_a;
                        alu_b     <= bus.req_b;
                        operation <= ALU_XOR;
                     end
                     OP_ADD: begin
                        alu_a     <= bus.req_a;
                        alu_b     <= bus.req_b;
                        operation <= ALU_ADD;
                     end
                     OP_SUB: begin
                        alu_a     <= bus.req_a;
                        alu_b     <= bus.req_b;
                        b_invert  <= 1'b1;
                        cin       <= 1'b1;
                        operation <= ALU_ADD;
                     end
                     OP_SLT: begin
                        alu_a     <= bus.req_a;
                        alu_b     <= bus.req_b;
                        b_invert  <= 1'b1;
                        cin       <= 1'b1;
                        operation <= ALU_LESS;
                     end
                     OP_NOR: begin
                        alu_a    <= bus.req_a;
                        alu_b    <= bus.req_b;
                        a_invert <= 1'b1;
                        b_invert <= 1'b1;
                     end
                     OP_SLL: begin
                        // X+X doubles X; a zero shift degenerates to A+0 in EXEC.
                        alu_a     <= bus.req_a;
                        operation <= ALU_ADD;
                        if (bus.req_b[SW-1:0] != '0) begin
                           alu_b <= bus.req_a;
                           cnt   <= bus.req_b[SW-1:0] - CNT_ONE;
                           state <= SHIFT;
                        end
                     end
`ifdef ALUSEQ_MUL_EN
                     OP_MUL: begin
                        acc       <= '0;
                        mcand     <= bus.req_a;
                        mplier    <= bus.req_b;
                        alu_b     <= bus.req_a;
                        operation <= ALU_ADD;
                        cnt       <= '1;
                        state     <= MUL;
                     end
`endif
                     default: ;
                  endcase
               end
            end

            EXEC: begin
               result_q <= illegal ? '0 : alu_result;
               cout_q   <= arith ? alu_cout : 1'b0;
               err_q    <= illegal;
               valid_q  <= 1'b1;
               state    <= DONE;
            end

            SHIFT: begin
               cout_q <= alu_cout;
               if (cnt == '0) begin
                  result_q <= alu_result;
                  err_q    <= 1'b0;
                  valid_q  <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt       <= cnt - CNT_ONE;
                  alu_a     <= alu_result;
                  alu_b     <= alu_result;
                  operation <= ALU_ADD;
               end
            end

`ifdef ALUSEQ_MUL_EN
            MUL: begin
               // The ALU only adds; the multiplicand shift stays local.
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt == '0) begin
                  result_q <= acc_next;
                  cout_q   <= 1'b0;
                  err_q    <= 1'b0;
                  valid_q  <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt       <= cnt - CNT_ONE;
                  alu_a     <= acc_next;
                  alu_b     <= mcand << 1;
                  operation <= ALU_ADD;
               end
            end
`endif

            DONE: begin
               if (bus.resp_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end

            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 16-bit ALU attached;
// honours ALUSEQ_MUL_EN the same way the design does.
module tb_alu_sequencer;
   typedef struct {
      logic [15:0] result;
      logic        cout;
      logic        err;
      int          latency;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] aluA;
   logic [15:0] aluB;
   logic        aInvert;
   logic        bInvert;
   logic        cinSig;
   logic [2:0]  operation;
   logic [15:0] aluResult;
   logic        aluCout;
   logic [15:0] effA;
   logic [15:0] effB;
   logic [16:0] aluSum;

   int   total = 0;
   int   bad = 0;
   int   cycle = 0;
   int   acceptCycle = 0;
   int   firstCycle = 0;
   bit   seenValid = 0;
   logic [15:0] firstRes;
   logic        firstCout;
   logic        firstErr;
   exp_t expQ[$];
   exp_t popped;

   alu_sequencer_if #(.WIDTH(16)) bus ();

   alu_sequencer #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_a      (aluA),
      .alu_b      (aluB),
      .a_invert   (aInvert),
      .b_invert   (bInvert),
      .cin        (cinSig),
      .operation  (operation),
      .alu_result (aluResult),
      .alu_cout   (aluCout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // External ALU: invert stage, shared adder, result mux.
   always_comb begin
      effA   = aInvert ? ~aluA : aluA;
      effB   = bInvert ? ~aluB : aluB;
      aluSum = {1'b0, effA} + {1'b0, effB} + {16'h0, cinSig};
      case (operation)
         3'b000:  aluResult = effA & effB;
         3'b010:  aluResult = effA | effB;
         3'b011:  aluResult = effA ^ effB;
         3'b100:  aluResult = aluSum[15:0];
         3'b101:  aluResult = {15'h0, aluSum[15]};
         default: aluResult = 16'h0;
      endcase
      aluCout = aluSum[16];
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Architectural result of each opcode, from plain arithmetic.
   function automatic exp_t refModel(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b);
      exp_t        e;
      logic [15:0] diff;
      logic [16:0] wide;
      logic [31:0] prod;
      int          n;
      e.result  = 16'h0;
      e.cout    = 1'b0;
      e.err     = 1'b0;
      e.latency = 2;
      diff      = a - b;
      case (op)
         4'd0: e.result = a & b;
         4'd1: e.result = a | b;
         4'd2: e.result = a ^ b;
         4'd3: {e.cout, e.result} = {1'b0, a} + {1'b0, b};
         4'd4: begin
            e.result = diff;
            e.cout   = (a >= b);
         end
         4'd5: begin
            e.result = {15'h0, diff[15]};
            e.cout   = (a >= b);
         end
         4'd6: e.result = ~(a | b);
         4'd7: begin
            n        = int'(b[3:0]);
            wide     = {1'b0, a} << n;
            e.result = wide[15:0];
            if (n > 0) begin
               e.cout    = wide[16];
               e.latency = n + 1;
            end
         end
`ifdef ALUSEQ_MUL_EN
         4'd8: begin
            prod      = a * b;
            e.result  = prod[15:0];
            e.latency = 17;
         end
`endif
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // ALU drive expected in the first cycle after acceptance: {A, B, ainv, binv, cin, op}.
   function automatic logic [37:0] expectedDrive(input logic [3:0] op,
                                                 input logic [15:0] a, input logic [15:0] b);
      logic [15:0] da;
      logic [15:0] db;
      logic        ai;
      logic        bi;
      logic        ci;
      logic [2:0]  sel;
      da = a;
      db = b;
      ai = 1'b0;
      bi = 1'b0;
      ci = 1'b0;
      sel = 3'b000;
      case (op)
         4'd0: ;
         4'd1: sel = 3'b010;
         4'd2: sel = 3'b011;
         4'd3: sel = 3'b100;
         4'd4: begin sel = 3'b100; bi = 1'b1; ci = 1'b1; end
         4'd5: begin sel = 3'b101; bi = 1'b1; ci = 1'b1; end
         4'd6: begin ai = 1'b1; bi = 1'b1; end
         4'd7: begin sel = 3'b100; db = (b[3:0] == 4'h0) ? 16'h0 : a; end
`ifdef ALUSEQ_MUL_EN
         4'd8: begin sel = 3'b100; da = 16'h0; db = a; end
`endif
         default: begin da = 16'h0; db = 16'h0; end
      endcase
      return {da, db, ai, bi, ci, sel};
   endfunction

   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input int stall);
      int waitCnt;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      waitCnt = 0;
      while (!bus.req_ready && waitCnt < 50) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      if (!bus.req_ready) begin
         checkOutput("accept_timeout", 64'd0, 64'd1);
         bus.req_valid = 1'b0;
         return;
      end
      expQ.push_back(refModel(op, a, b));
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'($urandom);
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      checkOutput("first_drive", {aluA, aluB, aInvert, bInvert, cinSig, operation},
                  expectedDrive(op, a, b));
      checkOutput("ready_busy", bus.req_ready, 1'b0);
      waitCnt = 0;
      while (!bus.resp_valid && waitCnt < 100) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      if (!bus.resp_valid) begin
         checkOutput("resp_timeout", 64'd0, 64'd1);
         expQ.delete();
         return;
      end
      repeat (stall) begin
         @(posedge clk);
         #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      checkOutput("ready_after_resp", bus.req_ready, 1'b1);
      checkOutput("valid_after_resp", bus.resp_valid, 1'b0);
   endtask

   // Monitor: checks hold behaviour in DONE and scores each handshake against the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seenValid = 0;
         end else begin
            if (bus.req_valid && bus.req_ready) acceptCycle = cycle + 1;
            if (bus.resp_valid) begin
               if (!seenValid) begin
                  seenValid  = 1;
                  firstCycle = cycle;
                  firstRes   = bus.resp_result;
                  firstCout  = bus.resp_cout;
                  firstErr   = bus.resp_err;
               end else begin
                  checkOutput("hold_result", bus.resp_result, firstRes);
                  checkOutput("hold_cout", bus.resp_cout, firstCout);
                  checkOutput("hold_err", bus.resp_err, firstErr);
               end
               checkOutput("ready_in_done", bus.req_ready, 1'b0);
               checkOutput("alu_idle_in_done",
                           {aluA, aluB, aInvert, bInvert, cinSig, operation}, 64'd0);
               if (bus.resp_ready) begin
                  if (expQ.size() == 0) begin
                     checkOutput("unexpected_resp", 64'd1, 64'd0);
                  end else begin
                     popped = expQ.pop_front();
                     checkOutput("result", bus.resp_result, popped.result);
                     checkOutput("cout", bus.resp_cout, popped.cout);
                     checkOutput("err", bus.resp_err, popped.err);
                     checkOutput("latency", 64'(firstCycle - acceptCycle + 1),
                                 64'(popped.latency));
                  end
                  seenValid = 0;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] op;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_op     = 4'h0;
      bus.req_a      = 16'h0;
      bus.req_b      = 16'h0;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", bus.req_ready, 1'b1);
      checkOutput("reset_resp", {bus.resp_valid, bus.resp_result, bus.resp_cout, bus.resp_err},
                  64'd0);
      checkOutput("reset_alu", {aluA, aluB, aInvert, bInvert, cinSig, operation}, 64'd0);
      rst_n = 1'b1;

      $display("[TB] directed vectors");
      applyStimulus(4'd3, 16'h7FFF, 16'h0001, 0);
      applyStimulus(4'd3, 16'hFFFF, 16'h0001, 1);
      applyStimulus(4'd4, 16'h0005, 16'h0007, 0);
      applyStimulus(4'd5, 16'h0005, 16'h0007, 2);
      applyStimulus(4'd7, 16'h8001, 16'h0003, 0);
      applyStimulus(4'd7, 16'h8001, 16'h0000, 0);
      applyStimulus(4'd7, 16'h8001, 16'h000F, 0);
      applyStimulus(4'd8, 16'h0012, 16'h0034, 0);
      applyStimulus(4'd8, 16'hFFFF, 16'hFFFF, 1);
      applyStimulus(4'd0, 16'hF0F0, 16'h3C3C, 0);
      applyStimulus(4'd1, 16'hF0F0, 16'h3C3C, 0);
      applyStimulus(4'd2, 16'hF0F0, 16'h3C3C, 0);
      applyStimulus(4'd6, 16'hF0F0, 16'h3C3C, 0);
      applyStimulus(4'd12, 16'h1234, 16'h5678, 0);

      $display("[TB] response stalled for 5 cycles");
      applyStimulus(4'd3, 16'h1111, 16'h2222, 5);

      $display("[TB] randomized requests");
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15))
                                          : 4'($urandom_range(0, 8));
         applyStimulus(op, 16'($urandom), 16'($urandom), $urandom_range(0, 3));
      end

      $display("[TB] reset in the middle of a long operation");
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
`ifdef ALUSEQ_MUL_EN
      bus.req_op    = 4'd8;
      bus.req_b     = 16'h00FF;
`else
      bus.req_op    = 4'd7;
      bus.req_b     = 16'h000F;
`endif
      bus.req_a     = 16'h0123;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      checkOutput("abandon_accepted", bus.req_ready, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("abandon_ready", bus.req_ready, 1'b1);
      checkOutput("abandon_valid", bus.resp_valid, 1'b0);
      checkOutput("abandon_alu", {aluA, aluB, aInvert, bInvert, cinSig, operation}, 64'd0);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("abandon_no_resp", bus.resp_valid, 1'b0);

      applyStimulus(4'd3, 16'h0F0F, 16'h00F1, 0);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Controller that owns the 16-bit ALU datapath, built from 16 one-bit ALU slices. It accepts one operation request at a time over a valid/ready handshake. It drives the ALU control lines (AInvert, BInvert, CIN, Operation) and operands. Single-pass ops finish in one ALU cycle; shift-left and multiply finish by iterating ADD passes through the ALU. It sits between instruction decode and the register-file writeback.

## Interface
- WIDTH, 16, datapath width; the ALU slice count.
- Clock  in  1  system clock; all state updates on the rising edge.
- ResetN  in  1  reset, synchronous and active-low.
- ReqValid  in  1  request present.
- ReqReady  out  1  sequencer can accept a request.
- ReqOp  in  4  0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT, 6 NOR, 7 SLL, 8 MUL; codes 9–15 are illegal.
- ReqA, ReqB  in  WIDTH  operands.
- AluA, AluB  out  WIDTH  ALU operands.
- AInvert, BInvert, CIN  out  1  ALU slice controls.
- Operation  out  3  ALU mux select: 000 AND, 010 OR, 011 XOR, 100 ADD, 101 LESS.
- AluResult  in  WIDTH  ALU result (combinational from AluA/AluB/controls).
- AluCout  in  1  carry out of the MSB slice.
- RespValid  out  1  result available.
- RespReady  in  1  consumer takes the result.
- RespResult  out  WIDTH  result.
- RespCout  out  1  carry / shifted-out bit.
- RespErr  out  1  illegal opcode.

## Operation
- States: IDLE, EXEC, SHIFT, MUL, DONE.
- ReqReady is 1 only in IDLE. A request is accepted on a cycle where ReqValid && ReqReady; ReqOp, ReqA and ReqB are latched on that cycle.
- Control mapping:
  - AND: Operation 000.
  - OR: Operation 010.
  - XOR: Operation 011.
  - ADD: Operation 100, CIN 0.
  - SUB: Operation 100, BInvert 1, CIN 1.
  - SLT: Operation 101, BInvert 1, CIN 1.
  - NOR: Operation 000, AInvert 1, BInvert 1.
- Ops 0–6 and illegal ops go IDLE→EXEC→DONE. An illegal op drives no ALU activity and gives result 0 with RespErr=1.
- SLL:
  - Shift amount n = ReqB[3:0].
  - n=0: go to EXEC with ADD A+0; result is A, Cout 0.
  - n>0: go to SHIFT. Each cycle drives AluA=AluB=X (ADD) and sets X←AluResult, recording the bit shifted out of X.
  - After n passes go to DONE. RespCout is the last bit shifted out.
- MUL:
  - 16 iterations. acc starts at 0, mcand = A, mplier = B.
  - Each iteration: if mplier[0], acc←AluResult, with the ALU doing ADD acc+mcand. Then mcand←mcand<<1 in a local register (not through the ALU), and mplier←mplier>>1.
  - Result is the low 16 bits of acc; RespCout=0.
- DONE: RespValid=1, with RespResult/RespCout/RespErr held stable until RespReady is 1, then return to IDLE.
- All ALU outputs are 0 in every state except EXEC/SHIFT/MUL.
- ResetN low at any time forces IDLE on the next edge and abandons an in-flight op with no response.

## Timing
- Accept edge = T.
- Single-pass ops: ALU driven during T+1; RespValid high from T+2.
- SLL with n>0: RespValid from T+1+n. SLL with n=0: RespValid from T+2.
- MUL: RespValid from T+17.
- DONE → IDLE on the edge where RespReady=1; ReqReady is high the following cycle. There is no back-to-back accept in the same cycle as response.
- Reset values: ReqReady 1 (IDLE), RespValid 0, RespResult 0, RespCout 0, RespErr 0, and AluA, AluB, AInvert, BInvert, CIN, Operation all 0.
- RespResult is captured from AluResult at the edge ending the last ALU pass, so it is registered.

## Configuration
- ALUSEQ_MUL_EN defined: op 8 is MUL, as above.
- ALUSEQ_MUL_EN undefined: the MUL state and its acc/mcand/mplier registers are not built. Op 8 is treated as illegal: EXEC→DONE, result 0, RespErr=1.

## Test plan
- ADD 0x7FFF+0x0001 -> RespValid at T+2, result 0x8000, Cout 0. Then ADD 0xFFFF+0x0001 -> result 0x0000, Cout 1.
- SUB 5-7 -> result 0xFFFE, Operation 100 with BInvert 1 and CIN 1 during EXEC. SLT 5,7 -> result 0x0001.
- SLL A=0x8001, B=0x0003 -> SHIFT for 3 cycles, result 0x0008, RespCout 0. SLL B=0 -> result 0x8001 at T+2.
- MUL 0x0012×0x0034 -> RespValid at T+17, result 0x03A8. MUL 0xFFFF×0xFFFF -> result 0x0001. Without ALUSEQ_MUL_EN: op 8 -> RespErr=1, result 0.
- RespReady held 0 for 5 cycles in DONE -> outputs stable and ReqReady 0 throughout. A new request is taken only after the RespReady handshake.
- ResetN low for 1 cycle mid-MUL (iteration 8) -> next cycle IDLE, RespValid 0, all ALU outputs 0, no response emitted.
